// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the IRAM read address, reassembles one- and
// two-word instructions and presents them to decode over valid/ready.
// Handles jump redirects from the core and halts on ENDOP.
// Optional build macro: NOP_SKIP_EN -- NOP opcodes are dropped in fetch
// instead of being presented to the core.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]     OP_LDAC  = 16'd7,
  parameter logic [15:0]     OP_STAC  = 16'd11,
  parameter logic [15:0]     OP_JUMP  = 16'd31,
  parameter logic [15:0]     OP_JUMPZ = 16'd33,
  parameter logic [15:0]     OP_ENDOP = 16'd37,
  parameter logic [15:0]     OP_NOP   = 16'd38
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [15:0]       iram_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr_opcode,
  output logic [15:0]       instr_operand,
  output logic              instr_two_word,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, REQ_OP, CAP_OP, REQ_ARG, CAP_ARG, VALID, HALT
  } state_t;

`ifdef NOP_SKIP_EN
  localparam logic NOP_SKIP = 1'b1;
`else
  localparam logic NOP_SKIP = 1'b0;
`endif

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, pc_inc, addr_d, ipc_d;
  logic [15:0]       opc_d, opr_d;
  logic              two_d, vld_d, halted_d;
  logic              op_two, skip_nop;

  assign pc_inc   = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign op_two   = iram_data inside {OP_LDAC, OP_STAC, OP_JUMP, OP_JUMPZ};
  assign skip_nop = NOP_SKIP && (iram_data == OP_NOP);
  assign busy     = (state != IDLE) && (state != HALT);

  // Next-state and next-value logic for the fetch sequencer and bundle registers
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    addr_d   = iram_addr;
    opc_d    = instr_opcode;
    opr_d    = instr_operand;
    two_d    = instr_two_word;
    ipc_d    = instr_pc;
    vld_d    = instr_valid;
    halted_d = halted;
    case (state)
      IDLE: begin
        if (jump_en)    pc_d = jump_addr;
        else if (start) begin addr_d = pc; state_d = REQ_OP; end
      end
      REQ_OP:  state_d = CAP_OP;
      CAP_OP: begin
        pc_d = pc_inc;
        if (skip_nop) begin
          addr_d  = pc_inc;
          state_d = REQ_OP;
        end else begin
          opc_d = iram_data;
          ipc_d = pc;
          two_d = op_two;
          if (op_two) begin
            addr_d  = pc_inc;
            state_d = REQ_ARG;
          end else begin
            opr_d   = '0;
            vld_d   = 1'b1;
            state_d = VALID;
          end
        end
      end
      REQ_ARG: state_d = CAP_ARG;
      CAP_ARG: begin
        opr_d   = iram_data;
        pc_d    = pc_inc;
        vld_d   = 1'b1;
        state_d = VALID;
      end
      VALID: begin
        if (instr_ready) begin
          // address parks at the next PC even when halting, so a later
          // resume and an observer both see the true fetch point
          addr_d = pc;
          vld_d  = 1'b0;
          if (instr_opcode == OP_ENDOP) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            state_d  = REQ_OP;
          end
        end
      end
      HALT: begin
        if (jump_en)    pc_d = jump_addr;
        else if (start) begin halted_d = 1'b0; addr_d = pc; state_d = REQ_OP; end
      end
      default: state_d = IDLE;
    endcase
    // redirect beats any in-progress fetch and any handshake outcome
    if (busy && jump_en) begin
      pc_d     = jump_addr;
      addr_d   = jump_addr;
      vld_d    = 1'b0;
      halted_d = 1'b0;
      state_d  = REQ_OP;
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      iram_addr      <= RESET_PC;
      instr_opcode   <= '0;
      instr_operand  <= '0;
      instr_two_word <= 1'b0;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_d;
      pc             <= pc_d;
      iram_addr      <= addr_d;
      instr_opcode   <= opc_d;
      instr_operand  <= opr_d;
      instr_two_word <= two_d;
      instr_pc       <= ipc_d;
      instr_valid    <= vld_d;
      halted         <= halted_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 64K x 16 registered-read IRAM model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, start, instr_ready, jump_en;
  logic [15:0] iram_addr, iram_data, jump_addr;
  logic        instr_valid, instr_two_word, halted, busy;
  logic [15:0] instr_opcode, instr_operand, instr_pc;
  logic [15:0] mem [0:65535];
  int          checks = 0, errors = 0;
  int          n;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .iram_addr(iram_addr),
    .iram_data(iram_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_two_word(instr_two_word), .instr_pc(instr_pc), .jump_en(jump_en),
    .jump_addr(jump_addr), .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  // IRAM: read registered on the edge after the address is presented
  always @(posedge clk) iram_data <= mem[iram_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; jump_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // edges after the current point until instr_valid rises (bounded)
  task automatic wait_vld(output int cnt);
    cnt = 0;
    do begin tick(); cnt++; end while (!instr_valid && cnt < 30);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    rst = 1'b1; start = 1'b0; instr_ready = 1'b1; jump_en = 1'b0; jump_addr = 16'h0;

    // reset state
    do_reset();
    chk("rst_vld", instr_valid, 0);
    chk("rst_addr", iram_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halt", halted, 0);
    chk("rst_opc", instr_opcode, 0);
    chk("rst_opr", instr_operand, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_two", instr_two_word, 0);

    // LDAC 25, MVAC, ENDOP
    mem[0] = 16'd7; mem[1] = 16'd25; mem[2] = 16'd15; mem[3] = 16'd37;
    pulse_start();
    chk("busy_run", busy, 1);
    wait_vld(n);
    chk("ldac_lat", n, 4);
    chk("ldac_opc", instr_opcode, 7);
    chk("ldac_opr", instr_operand, 25);
    chk("ldac_two", instr_two_word, 1);
    chk("ldac_pc", instr_pc, 0);
    tick();
    chk("ldac_hs_vld", instr_valid, 0);
    chk("ldac_next_addr", iram_addr, 2);
    wait_vld(n);
    chk("mvac_lat", n, 2);
    chk("mvac_opc", instr_opcode, 15);
    chk("mvac_opr", instr_operand, 0);
    chk("mvac_two", instr_two_word, 0);
    chk("mvac_pc", instr_pc, 2);
    tick();
    wait_vld(n);
    chk("end_lat", n, 2);
    chk("end_opc", instr_opcode, 37);
    chk("end_pc", instr_pc, 3);
    tick();
    chk("halt_flag", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_vld", instr_valid, 0);
    chk("halt_addr", iram_addr, 4);
    tick(); tick();
    chk("halt_addr_frozen", iram_addr, 4);
    chk("halt_stay", halted, 1);

    // resume after ENDOP, stall with ready low
    mem[4] = 16'd11; mem[5] = 16'd200; mem[6] = 16'd37;
    instr_ready = 1'b0;
    pulse_start();
    chk("resume_halt", halted, 0);
    wait_vld(n);
    chk("stac_lat", n, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_vld", instr_valid, 1);
      chk("stall_opc", instr_opcode, 11);
      chk("stall_opr", instr_operand, 200);
      chk("stall_pc", instr_pc, 4);
      chk("stall_addr", iram_addr, 5);
    end
    instr_ready = 1'b1;
    tick();
    chk("stall_hs_vld", instr_valid, 0);
    chk("stall_hs_addr", iram_addr, 6);
    wait_vld(n);
    chk("end2_lat", n, 2);
    chk("end2_pc", instr_pc, 6);
    tick();
    chk("end2_halt", halted, 1);

    // jump together with handshake
    do_reset();
    mem[0] = 16'd31; mem[1] = 16'd100; mem[100] = 16'd17;
    pulse_start();
    wait_vld(n);
    chk("jmp_opc", instr_opcode, 31);
    chk("jmp_opr", instr_operand, 100);
    jump_en = 1'b1; jump_addr = 16'd100;
    tick();
    jump_en = 1'b0;
    chk("jmp_hs_vld", instr_valid, 0);
    chk("jmp_addr", iram_addr, 100);
    wait_vld(n);
    chk("jmp_tgt_lat", n, 2);
    chk("jmp_tgt_opc", instr_opcode, 17);
    chk("jmp_tgt_pc", instr_pc, 100);

    // jump during CAP_ARG discards the LDAC
    do_reset();
    mem[0] = 16'd7; mem[1] = 16'd25; mem[50] = 16'd15;
    pulse_start();
    tick(); tick(); tick();
    chk("cap_arg_vld", instr_valid, 0);
    jump_en = 1'b1; jump_addr = 16'd50;
    tick();
    jump_en = 1'b0;
    chk("redir_vld", instr_valid, 0);
    chk("redir_addr", iram_addr, 50);
    wait_vld(n);
    chk("redir_lat", n, 2);
    chk("redir_pc", instr_pc, 50);
    chk("redir_opc", instr_opcode, 15);

    // PC wrap through 0xFFFF, jump in IDLE only moves PC
    do_reset();
    mem[16'hFFFF] = 16'd7; mem[0] = 16'd9;
    jump_en = 1'b1; jump_addr = 16'hFFFF;
    tick();
    jump_en = 1'b0;
    chk("idle_jmp_busy", busy, 0);
    chk("idle_jmp_addr", iram_addr, 0);
    pulse_start();
    wait_vld(n);
    chk("wrap_lat", n, 4);
    chk("wrap_pc", instr_pc, 16'hFFFF);
    chk("wrap_opr", instr_operand, 9);
    tick();
    chk("wrap_next_addr", iram_addr, 1);

    // reset during REQ_ARG
    do_reset();
    mem[0] = 16'd7; mem[1] = 16'd25;
    pulse_start();
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vld", instr_valid, 0);
    chk("mid_rst_addr", iram_addr, 0);
    pulse_start();
    wait_vld(n);
    chk("post_rst_pc", instr_pc, 0);
    chk("post_rst_opr", instr_operand, 25);

    // NOP handling
    do_reset();
    mem[0] = 16'd38; mem[1] = 16'd23;
    pulse_start();
    wait_vld(n);
`ifdef NOP_SKIP_EN
    chk("nop_lat", n, 4);
    chk("nop_opc", instr_opcode, 23);
    chk("nop_pc", instr_pc, 1);
`else
    chk("nop_lat", n, 2);
    chk("nop_opc", instr_opcode, 38);
    chk("nop_opr", instr_operand, 0);
    chk("nop_pc", instr_pc, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of IRAM: drives the IRAM read address and consumes the IRAM read data.
- Maintains the program counter and reassembles one-word and two-word instructions.
- Presents each instruction to the core's decode/execute stage over a valid/ready handshake.
- Accepts jump redirects from the core and halts on ENDOP.

Parameters:
- ADDR_W, 16, width of PC and IRAM address (IRAM is 64K x 16).
- RESET_PC, 16'd0, PC value loaded on reset.
- OP_LDAC, 16'd7, opcode encoding; two-word.
- OP_STAC, 16'd11, opcode encoding; two-word.
- OP_JUMP, 16'd31, opcode encoding; two-word.
- OP_JUMPZ, 16'd33, opcode encoding; two-word.
- OP_ENDOP, 16'd37, halt opcode; single-word.
- OP_NOP, 16'd38, no-op opcode; single-word.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin fetching from the current PC; sampled only in IDLE or HALT.
- iram_addr  out  ADDR_W  registered read address to IRAM.
- iram_data  in  16  IRAM read data, valid one clk after iram_addr is sampled.
- instr_valid  out  1  instruction bundle is valid.
- instr_ready  in  1  core accepts the bundle.
- instr_opcode  out  16  opcode word.
- instr_operand  out  16  operand word; 0 for single-word instructions.
- instr_two_word  out  1  set for LDAC/STAC/JUMP/JUMPZ.
- instr_pc  out  ADDR_W  address of the opcode word.
- jump_en  in  1  redirect request.
- jump_addr  in  ADDR_W  redirect target.
- halted  out  1  ENDOP has been consumed; fetch stopped.
- busy  out  1  state is not IDLE and not HALT.

Behaviour:
- Reset: pc=RESET_PC, iram_addr=RESET_PC, state=IDLE. All instr_* outputs=0; halted=0, busy=0.
- IRAM timing: IRAM registers its read at the edge after iram_addr is stable. Each word therefore costs 2 cycles: REQ (address held), then CAP (iram_data valid, captured at end of cycle).
- States:
  - IDLE: start=1 -> iram_addr<=pc, go REQ_OP.
  - REQ_OP: -> CAP_OP.
  - CAP_OP: instr_opcode<=iram_data, instr_pc<=pc, pc<=pc+1.
    - If the opcode is two-word: iram_addr<=pc+1, go REQ_ARG.
    - Otherwise: instr_operand<=0, go VALID.
  - REQ_ARG: -> CAP_ARG.
  - CAP_ARG: instr_operand<=iram_data, pc<=pc+1, go VALID.
  - VALID: instr_valid=1, bundle held stable until instr_ready=1.
    - On handshake with ENDOP: go HALT, halted<=1.
    - On handshake otherwise: iram_addr<=pc, go REQ_OP.
  - HALT: halted=1, instr_valid=0. start=1 -> halted<=0, iram_addr<=pc, go REQ_OP. Resumes after ENDOP.
- Latency: start to instr_valid is 2 edges for a single-word instruction, 4 for two-word. Back-to-back single-word throughput is one instruction per 3 cycles with ready tied high.
- instr_valid is a registered output: it rises on the edge entering VALID and falls on the edge leaving it.
- Jump redirect:
  - jump_en=1 in any busy state: pc<=jump_addr, iram_addr<=jump_addr, instr_valid<=0, go REQ_OP. Any partially fetched instruction is discarded.
  - jump_en together with a VALID handshake: the instruction counts as consumed, and the jump wins over normal sequencing, including over ENDOP.
  - jump_en in IDLE or HALT: pc<=jump_addr only; no fetch starts.
- Unknown opcodes are treated as single-word and passed through unchanged.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1=0. A two-word opcode at 0xFFFF takes its operand from 0x0000.
- rst mid-operation overrides everything: the in-flight word is dropped and state returns to IDLE next edge.
- start while busy is ignored.

Optional Feature:
- NOP_SKIP_EN defined: in CAP_OP an opcode equal to OP_NOP is not presented. pc<=pc+1, iram_addr<=pc+1, go REQ_OP directly; instr_valid stays 0.
- NOP_SKIP_EN undefined: NOP is presented as a normal single-word instruction with operand 0.

Test Plan:
- IRAM[0]=7, [1]=25, reset, start pulse at edge E0, ready=1 -> instr_valid after E4: opcode=7, operand=25, two_word=1, instr_pc=0; next iram_addr=2.
- IRAM[2]=15, [3]=37 after the above -> MVAC valid with operand=0, instr_pc=2. Then ENDOP valid at instr_pc=3; after its handshake halted=1, busy=0, iram_addr frozen at 4.
- Bundle valid with ready=0 for 5 cycles -> opcode/operand/pc unchanged and no new iram_addr. Ready=1 -> exactly one handshake.
- IRAM[0]=31, [1]=100, [100]=17: core asserts jump_en, jump_addr=100 with the handshake -> next bundle opcode=17, instr_pc=100.
- jump_en=1 (addr=50) during CAP_ARG of an LDAC -> the LDAC is never presented; next bundle has instr_pc=50.
- IRAM[0xFFFF]=7, [0]=9, pc=0xFFFF via jump -> operand=9, pc wraps to 1.
- rst during REQ_ARG -> IDLE next edge, instr_valid=0, pc=RESET_PC.
- Optional, NOP_SKIP_EN: IRAM[0]=38, [1]=23 -> first bundle is opcode=23, instr_pc=1.
